int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt controller that sits directly upstream of the single-cycle core and drives its `INT` input. It does the following for up to `N_SRC` external sources:

- synchronises each source and detects its rising edge;
- latches the source as pending, with per-source enables;
- arbitrates by fixed priority;
- holds a request / acknowledge / end-of-interrupt handshake with the core, so that only one interrupt is in service at a time.

## Interface
Parameters:
- `N_SRC`, 4: number of interrupt sources, range 2..16.
- `ID_W`, `$clog2(N_SRC)`: width of the source index.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `irq` in `N_SRC`: raw asynchronous source lines; a rising edge requests service.
- `en_wr` in 1: one-cycle strobe that loads the enable register.
- `en_data` in `N_SRC`: new enable value, taken when `en_wr`=1.
- `int_ack` in 1: core has entered the handler; sampled only in REQ.
- `eoi` in 1: one-cycle end-of-interrupt strobe from the core; sampled only in SERVICE.
- `INT` out 1: interrupt request to the core.
- `int_id` out `ID_W`: index of the source being requested or serviced.
- `pending` out `N_SRC`: pending register, for debug and readback.
- `en` out `N_SRC`: enable register.

## Operation
- Each `irq[i]` passes through a 2-flop synchroniser, then a registered edge detector: `rise[i] = s2[i] & ~s2_d[i]`.
- `rise[i]` sets `pending[i]` regardless of `en[i]`. Disabled sources stay pending and become eligible as soon as they are enabled.
- Eligible vector: `elig = pending & en`. Priority is fixed, and the lowest index wins.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: when `elig` ≠ 0, capture the winning index into `int_id` and go to REQ. Otherwise stay in IDLE.
  - REQ: `INT`=1. `int_id` is frozen. When `int_ack`=1, go to SERVICE. The request is never withdrawn, even if `en[int_id]` is cleared while in REQ.
  - SERVICE: `INT`=0. When `eoi`=1, clear `pending[int_id]` and go to IDLE.
- Simultaneous `rise[int_id]` and `eoi` clear on the same cycle: the set wins, so `pending` stays 1 and the source is requested again.
- `eoi` outside SERVICE and `int_ack` outside REQ are ignored, with no state change.
- `en_wr` takes effect at the next edge in any state. It does not alter the in-flight `int_id`.
- No nesting: a higher-priority rise during REQ or SERVICE only sets pending and waits for IDLE.

## Timing
- Reset (asynchronous, immediate): FSM=IDLE, `INT`=0, `int_id`=0, `pending`=0, `en`=0, and all synchroniser and edge flops cleared.
- Latency: `irq[i]` first sampled high at edge k gives `pending[i]`=1 after edge k+2. If enabled and IDLE, `INT`=1 after edge k+3.
- `INT` is decoded from the registered state (state==REQ), so it is glitch-free.
- `int_ack` seen high at edge m makes `INT`=0 after edge m.
- `eoi` at edge m gives IDLE after m. The next request can assert `INT` after edge m+1, giving at least one IDLE cycle between services.
- A pulse on `irq` shorter than one `clk` period may be missed; sources must hold high for at least 2 cycles.
- `rst` asserted mid-REQ or mid-SERVICE drops `INT` immediately and discards all pending state.

## Structure
- Shared package `int_pkg` holds:
  - the state encoding as localparams: IDLE=2'b00, REQ=2'b01, SERVICE=2'b10;
  - the maximum-source constant `INT_MAX_SRC`=16.
- Sub-module `irq_sync_edge` is per-source, instantiated `N_SRC` times via generate. It contains the synchroniser, the edge register and the `rise` output, and has the same `clk`/`rst`.
- The top holds `pending`, `en`, the priority encoder (function or loop), and the FSM.

## Test plan
All scenarios use `N_SRC`=4.
- Reset/enable: after `rst`, `en_wr` with `en_data`=4'b1111 gives `en`=4'hF and `INT`=0. Raise `irq[2]` at edge k: `pending`=4'b0100 after k+2, `INT`=1 with `int_id`=2 after k+3.
- Handshake: in REQ, hold `int_ack`=0 for 5 cycles, then `INT` stays 1. Pulse `int_ack`: `INT`=0 next cycle. Pulse `eoi`: `pending[2]`=0 and FSM returns to IDLE.
- Priority: raise `irq[3]` and `irq[1]` on the same cycle. Service order must be `int_id`=1 then `int_id`=3, each with its own ack/eoi, and one IDLE cycle between them.
- Masking: with `en`=4'b1110, raise `irq[0]`: `pending[0]`=1 but `INT` stays 0. Write `en`=4'b1111: `INT`=1 with `int_id`=0 two edges later.
- Set-wins race: `irq[1]` rising edge lands on the same cycle as `eoi` for `int_id`=1. `pending[1]` stays 1 and `INT` reasserts with `int_id`=1.
- Reset mid-service: assert `rst` in SERVICE with `pending`=4'b1010. All outputs return to reset values immediately, and after release `INT` stays 0 with no new edges.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding and source limit.
package int_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      REQ     = 2'b01,
      SERVICE = 2'b10
   } state_t;

   localparam int INT_MAX_SRC = 16;

endpackage

// File: rtl/int_ctrl_irq_sync_edge.sv
// Per-source 2-flop synchroniser followed by a registered rising-edge detector.
module irq_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic irq_i,
   output logic rise_o
);

   logic s1_q;
   logic s2_q;
   logic s2_dly_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s2_dly_q <= 1'b0;
      end else begin
         s1_q     <= irq_i;
         s2_q     <= s1_q;
         s2_dly_q <= s2_q;
      end
   end

   assign rise_o = s2_q & ~s2_dly_q;

endmodule

// File: rtl/int_ctrl.sv
// Fixed-priority interrupt controller with pending/enable registers and a
// request / acknowledge / end-of-interrupt handshake towards the core.
module int_ctrl
   import int_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int ID_W  = $clog2(N_SRC)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq,
   input  logic             en_wr,
   input  logic [N_SRC-1:0] en_data,
   input  logic             int_ack,
   input  logic             eoi,
   output logic             INT,
   output logic [ID_W-1:0]  int_id,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] en
);

   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] pending_q;
   logic [N_SRC-1:0] pending_d;
   logic [N_SRC-1:0] en_q;
   logic [N_SRC-1:0] elig;
   logic [N_SRC-1:0] clr;
   state_t           state_q;
   logic             int_q;
   logic [ID_W-1:0]  id_q;

   for (genvar g = 0; g < N_SRC; g++) begin : g_src
      irq_sync_edge u_sync (
         .clk    (clk),
         .rst    (rst),
         .irq_i  (irq[g]),
         .rise_o (rise[g])
      );
   end

   // Lowest set index wins; scanning downward leaves the smallest hit last.
   function automatic logic [ID_W-1:0] first_set(input logic [N_SRC-1:0] v);
      first_set = '0;
      for (int unsigned i = N_SRC; i > 0; i--) begin
         if (v[i-1]) first_set = ID_W'(i - 1);
      end
   endfunction

   always_comb begin
      elig = pending_q & en_q;
      clr  = '0;
      if (state_q == SERVICE && eoi) clr[id_q] = 1'b1;
      // A rise arriving with the clear keeps the source pending.
      pending_d = (pending_q & ~clr) | rise;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
         en_q      <= '0;
      end else begin
         pending_q <= pending_d;
         if (en_wr) en_q <= en_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         int_q   <= 1'b0;
         id_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|elig) begin
                  id_q    <= first_set(elig);
                  state_q <= REQ;
                  int_q   <= 1'b1;
               end
            end
            REQ: begin
               if (int_ack) begin
                  state_q <= SERVICE;
                  int_q   <= 1'b0;
               end
            end
            SERVICE: begin
               if (eoi) state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               int_q   <= 1'b0;
            end
         endcase
      end
   end

   assign INT     = int_q;
   assign int_id  = id_q;
   assign pending = pending_q;
   assign en      = en_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with a scoreboard queue of expected values.
module tb_int_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] irq;
   logic       en_wr;
   logic [3:0] en_data;
   logic       int_ack;
   logic       eoi;
   logic       INT;
   logic [1:0] int_id;
   logic [3:0] pending;
   logic [3:0] en;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   int_ctrl #(.N_SRC(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .irq     (irq),
      .en_wr   (en_wr),
      .en_data (en_data),
      .int_ack (int_ack),
      .eoi     (eoi),
      .INT     (INT),
      .int_id  (int_id),
      .pending (pending),
      .en      (en)
   );

   task automatic tick(input int unsigned n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_v(input logic [31:0] e);
      exp_q.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   task automatic ack_pulse();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic eoi_pulse();
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
   endtask

   initial begin
      rst = 1'b1; irq = '0; en_wr = 1'b0; en_data = '0; int_ack = 1'b0; eoi = 1'b0;

      // Reset state, before any clock edge
      expect_v(32'h0); expect_v(32'h0); expect_v(32'h0); expect_v(32'h0);
      #2;
      chk("rst_INT", INT); chk("rst_id", int_id); chk("rst_pend", pending); chk("rst_en", en);
      tick(2);
      rst = 1'b0;
      tick();

      // Enable all, then irq[2]
      en_wr = 1'b1; en_data = 4'hF;
      expect_v(32'hF); expect_v(32'h0);
      tick();
      en_wr = 1'b0;
      chk("en_all", en); chk("en_INT", INT);
      irq[2] = 1'b1;
      expect_v(32'h0); expect_v(32'h4); expect_v(32'h0); expect_v(32'h1); expect_v(32'h2);
      tick(2);                       // edges k, k+1
      chk("irq2_pend_k1", pending);
      tick();                        // k+2
      chk("irq2_pend_k2", pending); chk("irq2_INT_k2", INT);
      tick();                        // k+3
      chk("irq2_INT_k3", INT); chk("irq2_id", int_id);

      // Handshake: ack held low keeps the request
      expect_v(32'h1); expect_v(32'h0); expect_v(32'h0); expect_v(32'h0);
      tick(5);
      chk("req_hold", INT);
      ack_pulse();
      chk("ack_INT", INT);
      eoi_pulse();
      chk("eoi_pend", pending);
      tick();
      chk("idle_INT", INT);
      irq[2] = 1'b0;
      tick(3);

      // Priority: irq[3] and irq[1] together; eoi in REQ is ignored
      irq[3] = 1'b1; irq[1] = 1'b1;
      expect_v(32'hA); expect_v(32'h1); expect_v(32'h1);
      tick(3);
      chk("prio_pend", pending);
      tick();
      chk("prio1_INT", INT); chk("prio1_id", int_id);
      expect_v(32'h1); expect_v(32'hA);
      eoi_pulse();
      chk("eoi_in_req_INT", INT); chk("eoi_in_req_pend", pending);
      expect_v(32'h0); expect_v(32'h0); expect_v(32'h8); expect_v(32'h1); expect_v(32'h3);
      ack_pulse();
      chk("prio1_ack", INT);
      eoi_pulse();                   // edge m
      chk("prio_gap_INT", INT); chk("prio_gap_pend", pending);
      tick();                        // m+1
      chk("prio3_INT", INT); chk("prio3_id", int_id);
      ack_pulse();

      // No nesting: irq[0] during service of 3 only sets pending
      irq[0] = 1'b1;
      expect_v(32'h0); expect_v(32'h9); expect_v(32'h3);
      tick(3);
      chk("nest_INT", INT); chk("nest_pend", pending); chk("nest_id", int_id);
      expect_v(32'h1); expect_v(32'h0);
      eoi_pulse();
      tick();
      chk("nest0_INT", INT); chk("nest0_id", int_id);
      ack_pulse();
      eoi_pulse();
      irq = '0;
      tick(3);

      // Masking
      en_wr = 1'b1; en_data = 4'b1110;
      tick();
      en_wr = 1'b0;
      irq[0] = 1'b1;
      expect_v(32'h1); expect_v(32'h0);
      tick(5);
      chk("mask_pend", pending); chk("mask_INT", INT);
      en_wr = 1'b1; en_data = 4'hF;
      expect_v(32'h0); expect_v(32'h1); expect_v(32'h0);
      tick();                        // write edge
      en_wr = 1'b0;
      chk("unmask_INT_w", INT);
      tick();
      chk("unmask_INT", INT); chk("unmask_id", int_id);
      // Clearing the enable in REQ does not withdraw the request
      en_wr = 1'b1; en_data = 4'h0;
      expect_v(32'h1); expect_v(32'h0);
      tick();
      en_wr = 1'b0;
      chk("req_keep_INT", INT); chk("req_keep_en", en);
      en_wr = 1'b1; en_data = 4'hF;
      tick();
      en_wr = 1'b0;
      ack_pulse();
      eoi_pulse();
      irq[0] = 1'b0;
      tick(3);

      // Set-wins race on pending[1]
      irq[1] = 1'b1;
      expect_v(32'h1); expect_v(32'h1);
      tick(4);
      chk("race_INT0", INT); chk("race_id0", int_id);
      irq[1] = 1'b0;
      ack_pulse();
      tick(3);
      irq[1] = 1'b1;
      tick(2);                       // edges k, k+1
      expect_v(32'h2); expect_v(32'h0); expect_v(32'h1); expect_v(32'h1);
      eoi_pulse();                   // edge k+2
      chk("race_pend", pending); chk("race_INT_gap", INT);
      tick();
      chk("race_INT", INT); chk("race_id", int_id);
      ack_pulse();
      eoi_pulse();
      irq = '0;
      tick(3);

      // Reset mid-service with pending = 1010
      irq[1] = 1'b1; irq[3] = 1'b1;
      expect_v(32'h1); expect_v(32'hA); expect_v(32'h0);
      tick(4);
      chk("rs_req", INT);
      ack_pulse();
      chk("rs_pend", pending); chk("rs_svc_INT", INT);
      rst = 1'b1;
      expect_v(32'h0); expect_v(32'h0); expect_v(32'h0); expect_v(32'h0);
      #1;
      chk("rs_INT", INT); chk("rs_id", int_id); chk("rs_pend0", pending); chk("rs_en", en);
      irq = '0;
      tick(2);
      rst = 1'b0;
      expect_v(32'h0); expect_v(32'h0);
      tick(6);
      chk("post_rs_INT", INT); chk("post_rs_pend", pending);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
